// File: rtl/char_lane_engine.sv
// rtl/char_lane_engine.sv - falling-character lane table with score/lives game FSM
// Optional combo scoring enabled by defining LANE_ENGINE_COMBO_EN.
module char_lane_engine #(
  parameter int NLANES      = 8,
  parameter int YW          = 10,
  parameter int LOWER_BOUND = 480,
  parameter int LIVES       = 3,
  parameter int LW          = $clog2(NLANES)
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          start,
  input  logic          tick,
  input  logic          spawn_valid,
  input  logic [LW-1:0] spawn_lane,
  input  logic [7:0]    spawn_char,
  input  logic [YW-1:0] spawn_y,
  input  logic [2:0]    spawn_speed,
  output logic          spawn_ready,
  input  logic          key_valid,
  input  logic [7:0]    key_ascii,
  input  logic [LW-1:0] q_lane,
  output logic          q_active,
  output logic [7:0]    q_char,
  output logic [YW-1:0] q_y,
  output logic [1:0]    state,
  output logic [7:0]    score,
  output logic [3:0]    lives,
  output logic [3:0]    combo,
  output logic          hit,
  output logic          miss,
  output logic          gameover
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_END = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [NLANES-1:0] act_q, act_d;
  logic [7:0]        chr_q [NLANES];
  logic [7:0]        chr_d [NLANES];
  logic [YW-1:0]     y_q   [NLANES];
  logic [YW-1:0]     y_d   [NLANES];
  logic [2:0]        spd_q [NLANES];
  logic [2:0]        spd_d [NLANES];
  logic [7:0]        score_q, score_d;
  logic [3:0]        lives_q, lives_d;
  logic              hit_q, hit_d, miss_q, miss_d;
`ifdef LANE_ENGINE_COMBO_EN
  logic [3:0]        combo_q, combo_d;
`endif

  logic [YW:0]       adv [NLANES];
  logic [NLANES-1:0] kill;
  logic              match_found;
  logic [7:0]        miss_cnt;
  logic [1:0]        inc;
  logic [8:0]        score_sum;

  always_comb begin
    spawn_ready = 1'b0;
    q_active    = 1'b0;
    q_char      = 8'd0;
    q_y         = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (state_q == S_PLAY && spawn_lane == LW'(i) && !act_q[i]) spawn_ready = 1'b1;
      if (q_lane == LW'(i)) begin
        q_active = act_q[i];
        q_char   = chr_q[i];
        q_y      = y_q[i];
      end
    end
  end

  // Lowest-index active lane holding the pressed character is the one removed.
  always_comb begin
    kill        = '0;
    match_found = 1'b0;
    for (int i = 0; i < NLANES; i++) begin
      adv[i] = {1'b0, y_q[i]} + {{(YW-2){1'b0}}, spd_q[i]};
      if (!match_found && act_q[i] && chr_q[i] == key_ascii) begin
        kill[i]     = 1'b1;
        match_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    chr_d    = chr_q;
    y_d      = y_q;
    spd_d    = spd_q;
    score_d  = score_q;
    lives_d  = lives_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    miss_cnt = 8'd0;
`ifdef LANE_ENGINE_COMBO_EN
    combo_d  = combo_q;
    inc      = (combo_q >= 4'd4) ? 2'd2 : 2'd1;
`else
    inc      = 2'd1;
`endif
    score_sum = {1'b0, score_q} + {7'd0, inc};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PLAY;
          act_d   = '0;
          for (int i = 0; i < NLANES; i++) begin
            chr_d[i] = 8'd0;
            y_d[i]   = '0;
            spd_d[i] = 3'd0;
          end
          score_d = 8'd0;
          lives_d = 4'(LIVES);
`ifdef LANE_ENGINE_COMBO_EN
          combo_d = 4'd0;
`endif
        end
      end
      S_PLAY: begin
        for (int i = 0; i < NLANES; i++) begin
          if (key_valid && kill[i]) begin
            act_d[i] = 1'b0;
            y_d[i]   = '0;
          end else if (tick && act_q[i]) begin
            if (adv[i] >= (YW+1)'(LOWER_BOUND)) begin
              act_d[i] = 1'b0;
              y_d[i]   = '0;
              miss_cnt = miss_cnt + 8'd1;
            end else begin
              y_d[i] = adv[i][YW-1:0];
            end
          end
          // A spawnable lane was inactive before the edge, so tick/key never touch it.
          if (spawn_valid && spawn_ready && spawn_lane == LW'(i)) begin
            act_d[i] = 1'b1;
            chr_d[i] = spawn_char;
            y_d[i]   = spawn_y;
            spd_d[i] = spawn_speed;
          end
        end
        if (miss_cnt >= {4'd0, lives_q}) lives_d = 4'd0;
        else                             lives_d = lives_q - miss_cnt[3:0];
        if (key_valid && match_found) begin
          score_d = (score_sum > 9'd99) ? 8'd99 : score_sum[7:0];
          hit_d   = 1'b1;
`ifdef LANE_ENGINE_COMBO_EN
          if (combo_q != 4'd15) combo_d = combo_q + 4'd1;
`endif
        end
`ifdef LANE_ENGINE_COMBO_EN
        if (miss_cnt != 8'd0 || (key_valid && !match_found)) combo_d = 4'd0;
`endif
        miss_d = (miss_cnt != 8'd0);
        if (miss_cnt != 8'd0 && lives_d == 4'd0) state_d = S_END;
      end
      S_END: begin
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      act_q   <= '0;
      for (int i = 0; i < NLANES; i++) begin
        chr_q[i] <= 8'd0;
        y_q[i]   <= '0;
        spd_q[i] <= 3'd0;
      end
      score_q <= 8'd0;
      lives_q <= 4'(LIVES);
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
`ifdef LANE_ENGINE_COMBO_EN
      combo_q <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      chr_q   <= chr_d;
      y_q     <= y_d;
      spd_q   <= spd_d;
      score_q <= score_d;
      lives_q <= lives_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
`ifdef LANE_ENGINE_COMBO_EN
      combo_q <= combo_d;
`endif
    end
  end

  assign state    = state_q;
  assign score    = score_q;
  assign lives    = lives_q;
  assign hit      = hit_q;
  assign miss     = miss_q;
  assign gameover = (state_q == S_END);
`ifdef LANE_ENGINE_COMBO_EN
  assign combo    = combo_q;
`else
  assign combo    = 4'd0;
`endif

endmodule
